muldiv_unit: RTL

Iterative RV32M multiply/divide unit sitting beside the ALU in the execute path. It consumes the two register-file read values (rs1/rs2) and the destination index for one instruction, computes over several cycles, and produces a single write-back beat (enable, address, data) that the write-back mux forwards to the register-file write port. The `busy` output stalls the fetch/PC logic while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_div_core.sv | 35 +++
 rtl/muldiv_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared width, opcode, state and special-result constants for the
// RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} muldiv_state_t;
  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;
endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: restoring divider on magnitudes, one quotient bit per i_step.
// Exposes next-step quotient/remainder so the final step can be registered by the top.
module muldiv_div_core import muldiv_pkg::*; #(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_quo_nxt,
  output logic [W-1:0] o_rem_nxt
);
  logic [W-1:0] r_rem, r_quo, r_dvs;
  logic [W:0] w_shift, w_trial;
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  // bit W of the trial difference is the borrow: set means keep the old partial remainder
  assign o_rem_nxt = w_trial[W] ? w_shift[W-1:0] : w_trial[W-1:0];
  assign o_quo_nxt = {r_quo[W-2:0], !w_trial[W]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_rem <= o_rem_nxt;
      r_quo <= o_quo_nxt;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide producing one write-back beat.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops finish at once with err set.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic            err
);
  import muldiv_pkg::*;
  localparam int CW = $clog2(XLEN);
  muldiv_state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_f3;
  logic r_neg, r_err;
  logic [XLEN-1:0] r_mc, r_result;
  logic [2*XLEN-1:0] r_prod;
  logic [4:0] r_wb_addr;
  logic w_accept, w_iter, w_last, w_s1, w_s2, w_n1, w_n2, w_special, w_spec_err;
  logic [XLEN-1:0] w_a, w_b, w_spec_res, w_mul_res, w_div_res;
  logic [XLEN:0] w_sum;
  logic [2*XLEN-1:0] w_prod_nxt, w_prod_fix;

  assign w_accept = start && r_state == S_IDLE;
  assign w_iter = r_state == S_MUL || r_state == S_DIV;
  assign w_last = r_cnt == CW'(XLEN - 1);
  // signed rs1: MULH, MULHSU, DIV, REM; signed rs2: MULH, DIV, REM
  assign w_s1 = funct3[2] ? !funct3[0] : funct3[1] ^ funct3[0];
  assign w_s2 = funct3[2] ? !funct3[0] : funct3[1:0] == 2'b01;
  assign w_n1 = w_s1 && rs1_val[XLEN-1];
  assign w_n2 = w_s2 && rs2_val[XLEN-1];
  assign w_a = w_n1 ? -rs1_val : rs1_val;
  assign w_b = w_n2 ? -rs2_val : rs2_val;
  // r_prod holds {partial high word, remaining multiplier bits}; one add-and-shift per cycle
  assign w_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mc} : '0);
  assign w_prod_nxt = {w_sum, r_prod[XLEN-1:1]};
  assign w_prod_fix = r_neg ? -w_prod_nxt : w_prod_nxt;
  assign w_mul_res = r_f3 == 2'b00 ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
  logic r_rneg, w_ovf, w_div0;
  logic [XLEN-1:0] w_quo_nxt, w_rem_nxt;
  assign w_div0 = rs2_val == '0;
  assign w_ovf = !funct3[0] && rs1_val == INT_MIN && rs2_val == DIV0_QUOT;
  assign w_special = w_div0 || w_ovf;
  assign w_spec_err = 1'b0;
  assign w_spec_res = w_div0 ? (funct3[1] ? rs1_val : DIV0_QUOT) : (funct3[1] ? '0 : INT_MIN);
  assign w_div_res = r_f3[1] ? (r_rneg ? -w_rem_nxt : w_rem_nxt) : (r_neg ? -w_quo_nxt : w_quo_nxt);
  muldiv_div_core #(.W(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_step     (r_state == S_DIV),
    .i_dividend (w_a),
    .i_divisor  (w_b),
    .o_quo_nxt  (w_quo_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rneg <= 1'b0;
    else if (w_accept) r_rneg <= w_n1;
`else
  assign w_special = 1'b1;
  assign w_spec_err = 1'b1;
  assign w_spec_res = '0;
  assign w_div_res = '0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = !funct3[2] ? S_MUL : w_special ? S_DONE : S_DIV;
    else if (w_iter && w_last) w_next = S_DONE;
    else if (r_state == S_DONE) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_f3 <= '0;
      r_neg <= 1'b0;
      r_err <= 1'b0;
      r_mc <= '0;
      r_prod <= '0;
      r_result <= '0;
      r_wb_addr <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_f3 <= funct3[1:0];
      r_neg <= w_n1 ^ w_n2;
      r_err <= funct3[2] && w_spec_err;
      r_mc <= w_a;
      r_prod <= {{XLEN{1'b0}}, w_b};
      r_wb_addr <= rd_addr;
      if (funct3[2] && w_special) r_result <= w_spec_res;
    end else if (w_iter) begin
      r_cnt <= r_cnt + 1'b1;
      r_prod <= w_prod_nxt;
      if (w_last) r_result <= r_state == S_MUL ? w_mul_res : w_div_res;
    end

  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign wb_en = done && r_wb_addr != '0 && !r_err;
  assign result = r_result;
  assign wb_addr = r_wb_addr;
  assign err = r_err;
endmodule
